// File: rtl/if_stage.sv
// RV32 instruction-fetch stage: PC register, single-outstanding imem fetch and
// the IF/ID pipeline register feeding the decoder.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [6:0]  id_opcode
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] hold_buf;
    logic        drop;
    logic        can_accept;

    assign can_accept     = !stall || !id_valid;
    assign imem_req_valid = rst_n && (state == S_REQ) && !redirect_valid;
    assign imem_addr      = pc;
    assign id_opcode      = id_valid ? id_instr[6:0] : 7'b0000000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            drop     <= 1'b0;
            hold_buf <= NOP_INSTR;
            id_valid <= 1'b0;
            id_pc    <= 32'h0000_0000;
            id_instr <= NOP_INSTR;
        end else if (redirect_valid) begin
            // Redirect flushes IF/ID and beats any stall.
            pc       <= {redirect_pc[31:2], 2'b00};
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            case (state)
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        drop  <= 1'b0;
                        state <= S_REQ;
                    end else begin
                        drop  <= 1'b1;
                    end
                end
                S_HOLD: begin
                    hold_buf <= NOP_INSTR;
                    state    <= S_REQ;
                end
                default: state <= S_REQ;
            endcase
        end else begin
            // Decode consumes the current entry; a load below takes precedence.
            if (id_valid && !stall)
                id_valid <= 1'b0;
            case (state)
                S_REQ: begin
                    if (imem_req_valid && imem_req_ready)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                        end else if (can_accept) begin
                            id_instr <= imem_rsp_data;
                            id_pc    <= pc;
                            id_valid <= 1'b1;
                            pc       <= pc + 32'd4;
                            state    <= S_REQ;
                        end else begin
                            hold_buf <= imem_rsp_data;
                            state    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        id_instr <= hold_buf;
                        id_pc    <= pc;
                        id_valid <= 1'b1;
                        pc       <= pc + 32'd4;
                        hold_buf <= NOP_INSTR;
                        state    <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus random traffic checked against a
// program-order model (instruction at PC p is mem(p), consumed PCs advance by 4).
module tb_if_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;

    if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_opcode      (id_opcode)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_cons   = 0;
    logic [31:0] exp_pc;
    logic        pend;
    int          cnt;
    logic [31:0] pend_addr;
    logic        prev_stuck;
    logic [31:0] prev_addr;
    logic [31:0] hs_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_f = 32'h0050_0093;
            32'h0000_0004: mem_f = 32'h00A0_0113;
            32'h0000_0008: mem_f = 32'h0020_81B3;
            default:       mem_f = (a * 32'h9E37_79B1) ^ 32'h0123_4567;
        endcase
    endfunction

    // One clock: drive at negedge, sample 1 time unit later, update model.
    task automatic cycle(input bit rst_in, input bit stall_in, input bit redir_in,
                         input logic [31:0] tgt, input bit ready_in, input int k,
                         input bit spurious);
        logic fire;
        @(negedge clk);
        rst_n          = !rst_in;
        stall          = stall_in;
        redirect_valid = redir_in;
        redirect_pc    = tgt;
        imem_req_ready = ready_in;
        fire = 1'b0;
        if (!rst_in) begin
            if (spurious) begin
                fire = 1'b1;
            end else if (pend) begin
                if (cnt == 0) begin
                    fire = 1'b1;
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
        imem_rsp_valid = fire;
        imem_rsp_data  = spurious ? 32'hDEAD_0033 : (fire ? mem_f(pend_addr) : $urandom);
        #1;
        if (rst_in) begin
            chk("req_in_reset", {31'b0, imem_req_valid}, 32'd0);
            pend       = 1'b0;
            exp_pc     = RESET_PC;
            prev_stuck = 1'b0;
        end else begin
            chk("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
            if (imem_req_valid && prev_stuck)
                chk("addr_stable", imem_addr, prev_addr);
            prev_stuck = imem_req_valid && !imem_req_ready;
            prev_addr  = imem_addr;
            if (imem_req_valid && imem_req_ready) begin
                pend      = 1'b1;
                cnt       = k - 1;
                pend_addr = imem_addr;
                hs_q.push_back(imem_addr);
            end
            if (!id_valid)
                chk("bubble_opcode", {25'b0, id_opcode}, 32'd0);
            if (redir_in) begin
                exp_pc = {tgt[31:2], 2'b00};
            end else if (id_valid && !stall_in) begin
                logic [31:0] e;
                e = mem_f(exp_pc);
                chk("id_pc", id_pc, exp_pc);
                chk("id_instr", id_instr, e);
                chk("id_opcode", {25'b0, id_opcode}, {25'b0, e[6:0]});
                exp_pc = exp_pc + 32'd4;
                n_cons++;
            end
        end
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 32'h0, 0, 1, 0);
        cycle(1, 0, 0, 32'h0, 0, 1, 0);
        hs_q.delete();
    endtask

    task automatic run(input int n, input bit ready_in, input int k);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 32'h0, ready_in, k, 0);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        pend = 1'b0; cnt = 0; pend_addr = 32'h0; prev_stuck = 1'b0; prev_addr = 32'h0;
        exp_pc = RESET_PC;

        // Reset state and basic streaming with a 1-cycle memory.
        do_reset();
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_instr", id_instr, NOP_INSTR);
        chk("rst_addr", imem_addr, RESET_PC);
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 0, 32'h0, 1, 1, 0);
            chk("pulse_id_valid", {31'b0, id_valid}, {31'b0, (i >= 2) && (i % 2 == 0)});
        end
        chk("stream_hs_cnt", hs_q.size(), 32'd10);
        if (hs_q.size() >= 3) begin
            chk("stream_addr0", hs_q[0], 32'h0);
            chk("stream_addr1", hs_q[1], 32'h4);
            chk("stream_addr2", hs_q[2], 32'h8);
        end

        // Stall while a response arrives, then redirect under stall.
        do_reset();
        run(2, 1, 1);
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 32'h0, 1, 1, 0);
        chk("hold_id_pc", id_pc, 32'h0);
        chk("hold_id_valid", {31'b0, id_valid}, 32'd1);
        chk("hold_no_req", {31'b0, imem_req_valid}, 32'd0);
        chk("hold_hs_cnt", hs_q.size(), 32'd2);
        cycle(0, 0, 0, 32'h0, 0, 1, 0);
        cycle(0, 1, 0, 32'h0, 0, 1, 0);
        chk("unhold_id_pc", id_pc, 32'h4);
        chk("unhold_id_instr", id_instr, 32'h00A0_0113);
        chk("unhold_next_addr", imem_addr, 32'h8);
        chk("unhold_req", {31'b0, imem_req_valid}, 32'd1);
        cycle(0, 1, 1, 32'h0000_0200, 0, 1, 0);
        cycle(0, 0, 0, 32'h0, 0, 1, 0);
        chk("rdst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rdst_opcode", {25'b0, id_opcode}, 32'd0);
        chk("rdst_addr", imem_addr, 32'h0000_0200);
        run(6, 1, 1);

        // Redirect while waiting; the late response must be dropped.
        do_reset();
        cycle(0, 0, 0, 32'h0, 1, 3, 0);
        cycle(0, 0, 1, 32'h0000_0103, 0, 1, 0);
        cycle(0, 0, 0, 32'h0, 0, 1, 0);
        cycle(0, 0, 0, 32'h0, 0, 1, 0);
        chk("drop_id_valid", {31'b0, id_valid}, 32'd0);
        cycle(0, 0, 0, 32'h0, 0, 1, 0);
        chk("drop_id_valid2", {31'b0, id_valid}, 32'd0);
        chk("drop_addr", imem_addr, 32'h0000_0100);
        chk("drop_req", {31'b0, imem_req_valid}, 32'd1);
        run(8, 1, 1);

        // PC wrap at the top of the address space.
        do_reset();
        cycle(0, 0, 1, 32'hFFFF_FFFF, 0, 1, 0);
        run(6, 1, 1);
        chk("wrap_hs_cnt_min", {31'b0, hs_q.size() >= 2}, 32'd1);
        if (hs_q.size() >= 2) begin
            chk("wrap_addr0", hs_q[0], 32'hFFFF_FFFC);
            chk("wrap_addr1", hs_q[1], 32'h0000_0000);
        end

        // Reset in WAIT; a stray response in REQ must be ignored.
        do_reset();
        cycle(0, 0, 0, 32'h0, 1, 3, 0);
        cycle(1, 0, 0, 32'h0, 0, 1, 0);
        cycle(0, 0, 0, 32'h0, 0, 1, 1);
        chk("mrst_addr", imem_addr, RESET_PC);
        chk("mrst_req", {31'b0, imem_req_valid}, 32'd1);
        chk("mrst_id_valid", {31'b0, id_valid}, 32'd0);
        cycle(0, 0, 0, 32'h0, 0, 1, 0);
        chk("stray_id_valid", {31'b0, id_valid}, 32'd0);
        chk("stray_req", {31'b0, imem_req_valid}, 32'd1);
        run(6, 1, 1);

        // Random traffic.
        do_reset();
        n_cons = 0;
        for (int i = 0; i < 4000; i++)
            cycle(0, 1'($urandom % 2), ($urandom % 20) == 0, $urandom,
                  ($urandom % 5) < 3, $urandom_range(1, 4), 0);
        chk("rand_progress", {31'b0, n_cons > 200}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
